// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hazard and flush controller for a six-stage pipeline.
//
// Generates per-stage hold signals for decode load-use stalls and for
// multi-cycle execute operations. It raises a one-cycle flush with a
// redirect address on exceptions, and keeps stall and flush performance
// counters.
//
// Ports:
//   clk          - system clock, rising edge
//   rst          - synchronous, active-high reset
//   stallreq_id  - decode-stage load-use stall request (level)
//   ex_start     - one-cycle pulse starting a multi-cycle execute op
//   ex_len[5:0]  - stall length of that op in cycles (sampled with ex_start)
//   excp_req     - exception/flush request (level)
//   excp_pc      - handler address accompanying excp_req
//   clr_cnt      - zeroes both performance counters on the next edge
//   stall[5:0]   - hold per stage: pc, if, id, ex, mem, wb (bit0..bit5)
//   flush        - pipeline flush strobe
//   new_pc       - fetch redirect address, zero unless flush=1
//   busy         - FSM is outside RUN
//   stall_cycles - wrapping count of cycles with any stage held
//   flush_count  - saturating count of flush cycles
module pipe_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        ex_start,
  input  logic [5:0]  ex_len,
  input  logic        excp_req,
  input  logic [31:0] excp_pc,
  input  logic        clr_cnt,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        busy,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_count
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    EXWAIT = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;

  state_t     state;
  logic [5:0] cnt;
  logic       ex_go;

  // A zero-length execute op is treated as if no ex_start was seen.
  assign ex_go = ex_start && (ex_len != 6'd0);

  // busy is suppressed during reset so the reset cycle itself looks idle
  // even though the state register has not yet been cleared.
  assign busy = !rst && (state != RUN);

  // Stall/flush/redirect act in the same cycle as their cause. Exceptions
  // override everything, and during reset the whole pipeline is released.
  always_comb begin
    stall  = STALL_NONE;
    flush  = 1'b0;
    new_pc = 32'h0;
    if (rst) begin
      stall  = STALL_NONE;
    end else if (excp_req) begin
      flush  = 1'b1;
      new_pc = excp_pc;
    end else begin
      case (state)
        RUN: begin
          if (ex_go)
            stall = STALL_EX;
          else if (stallreq_id)
            stall = STALL_ID;
        end
        EXWAIT:  stall = STALL_EX;
        FLUSH:   stall = STALL_NONE;
        default: stall = STALL_NONE;
      endcase
    end
  end

  // State, op countdown and performance counters. cnt holds the number of
  // stall cycles still owed after the current one, so the start cycle plus
  // the EXWAIT cycles add up to exactly ex_len. Counter clear wins over an
  // increment in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      cnt          <= 6'd0;
      stall_cycles <= 32'd0;
      flush_count  <= 16'd0;
    end else begin
      if (excp_req) begin
        state <= FLUSH;
        cnt   <= 6'd0;
      end else begin
        case (state)
          RUN: begin
            if (ex_go) begin
              cnt <= ex_len - 6'd1;
              if (ex_len > 6'd1)
                state <= EXWAIT;
            end
          end
          EXWAIT: begin
            cnt <= cnt - 6'd1;
            if (cnt <= 6'd1)
              state <= RUN;
          end
          FLUSH:   state <= RUN;
          default: state <= RUN;
        endcase
      end

      if (clr_cnt) begin
        stall_cycles <= 32'd0;
        flush_count  <= 16'd0;
      end else begin
        if (stall != STALL_NONE)
          stall_cycles <= stall_cycles + 32'd1;
        if (flush && (flush_count != 16'hFFFF))
          flush_count <= flush_count + 16'd1;
      end
    end
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all state updates on the rising edge.
REQ-002 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-003 SHALL have port stallreq_id, input, 1, decode-stage load-use stall request (level).
REQ-004 SHALL have port ex_start, input, 1, single-cycle pulse marking the start of a multi-cycle execute operation.
REQ-005 SHALL have port ex_len, input, 6, number of stall cycles for that operation (0..63); sampled only with ex_start.
REQ-006 SHALL have port excp_req, input, 1, exception/flush request (level, evaluated each cycle).
REQ-007 SHALL have port excp_pc, input, 32, handler address accompanying excp_req.
REQ-008 SHALL have port clr_cnt, input, 1, clears performance counters.
REQ-009 SHALL have port stall, output, 6, per-stage hold: bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb.
REQ-010 SHALL have port flush, output, 1, pipeline flush strobe.
REQ-011 SHALL have port new_pc, output, 32, fetch redirect address; valid only while flush=1.
REQ-012 SHALL have port busy, output, 1, high when FSM is not in RUN.
REQ-013 SHALL have port stall_cycles, output, 32, count of cycles with stall!=0.
REQ-014 SHALL have port flush_count, output, 16, count of flushes.

Function
REQ-015 SHALL implement FSM states RUN, EXWAIT, FLUSH plus a 6-bit down-counter cnt.
REQ-016 stall, flush, new_pc SHALL be combinational from current state and inputs (same-cycle effect); state, cnt and counters SHALL be registered.
REQ-017 Priority SHALL be excp_req > EXWAIT/ex_start > stallreq_id.
REQ-018 excp_req=1 in any state SHALL drive flush=1, new_pc=excp_pc, stall=6'b000000 that cycle, clear cnt, and set next state FLUSH.
REQ-019 When flush=0, new_pc SHALL be 32'h0.
REQ-020 RUN, no excp_req, ex_start=1, ex_len>0: stall=6'b001111 this cycle, cnt<=ex_len-1, next state EXWAIT if ex_len>1, else stay in RUN.
REQ-021 RUN, ex_start=1 with ex_len=0: the ex_start SHALL be ignored.
REQ-022 RUN, otherwise: stall=6'b000111 if stallreq_id=1, else 6'b000000.
REQ-023 EXWAIT, no excp_req: stall=6'b001111, cnt decrements by 1; when cnt==1, next state RUN. Total stall length SHALL equal exactly ex_len cycles including the start cycle.
REQ-024 EXWAIT: ex_start SHALL be ignored (protocol violation, no state change); stallreq_id SHALL be subsumed.
REQ-025 FLUSH: lasts exactly one cycle; stall=0, flush=0; stallreq_id and ex_start SHALL be ignored; next state RUN.
REQ-026 FLUSH with excp_req=1: REQ-018 SHALL apply (re-flush), and the state SHALL remain FLUSH.
REQ-027 busy SHALL be 1 iff state is EXWAIT or FLUSH.
REQ-028 stall_cycles SHALL increment each cycle stall!=0 and wrap from FFFFFFFF to 0.
REQ-029 flush_count SHALL increment each cycle flush=1 and saturate at 16'hFFFF.
REQ-030 clr_cnt=1 SHALL zero both counters next cycle; clr_cnt SHALL win over a simultaneous increment.

Reset
REQ-031 While rst=1 the block SHALL force stall=0, flush=0, new_pc=0 regardless of inputs.
REQ-032 While rst=1 the next state SHALL be RUN, with cnt=0, stall_cycles=0, flush_count=0, busy=0.
REQ-033 rst asserted mid-EXWAIT or in FLUSH SHALL abort the operation with no residual stall after reset deasserts.

Verification
REQ-034 Load-use: RUN, stallreq_id=1 for 2 cycles -> stall=000111 for exactly those 2 cycles; stall_cycles=2.
REQ-035 Multi-cycle: ex_start=1, ex_len=5 -> stall=001111 for exactly 5 consecutive cycles; busy=1 cycles 2-5; then RUN, stall=0.
REQ-036 Abort: ex_len=32, excp_req=1 with excp_pc=32'h80000180 on the 4th stall cycle -> flush=1, new_pc=80000180, stall=0 that cycle; FLUSH for one cycle; then RUN.
REQ-037 Edge lengths: ex_len=0 -> no stall; ex_len=1 -> one stall cycle with no EXWAIT entry (busy stays 0).
REQ-038 Counters: 65537 flushes -> flush_count=FFFF; clr_cnt asserted with a stalled cycle -> both counters 0 next cycle.
REQ-039 Reset: rst=1 during EXWAIT with stallreq_id=1 -> stall=0 immediately; after release busy=0 and all counters 0.
